mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 md_start  input  1  E-stage instruction is an MD op and is not stalled; qualifies md_op.
REQ-006 md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved.
REQ-007 rs_val  input  32  forwarded rs operand (dividend/multiplicand; mthi/mtlo source).
REQ-008 rt_val  input  32  forwarded rt operand (divisor/multiplier).
REQ-009 d_uses_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  MD operation in progress.
REQ-011 stall  output  1  combinational stall request to the D stage.
REQ-012 done  output  1  one-cycle pulse on the edge that commits a mult/div result.
REQ-013 hi  output  32  HI register, read by mfhi.
REQ-014 lo  output  32  LO register, read by mflo.

Function
REQ-015 FSM states: IDLE and BUSY; 5-bit down-counter cnt.
REQ-016 IDLE with md_start=1 and md_op in 1..4: latch rs_val/rt_val/md_op; cnt <= MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); go to BUSY.
REQ-017 busy SHALL be high exactly when state is BUSY, i.e. from the cycle after the start edge for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-018 BUSY with cnt>1: cnt <= cnt-1, hi/lo unchanged.
REQ-019 BUSY with cnt==1: hi/lo <= result, done <= 1 for one cycle, state <= IDLE.
REQ-020 A result is visible on hi/lo in the cycle busy falls.
REQ-021 mult: signed 32x32 -> 64-bit product; hi = [63:32], lo = [31:0].
REQ-022 multu: as mult, with unsigned operands.
REQ-023 div: lo = signed quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
REQ-024 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-025 div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-026 Divisor zero (div/divu): full busy duration still elapses; done pulses; hi/lo retain their previous values.
REQ-027 IDLE with md_start=1 and md_op=5: hi <= rs_val on that edge, no busy. md_op=6: lo <= rs_val likewise.
REQ-028 md_start while BUSY (any op) is ignored; the in-flight op and its latched operands are unaffected.
REQ-029 md_op 0 or 7 with md_start=1: no effect.
REQ-030 stall = d_uses_md & (busy | (md_start & md_op in 1..4)), combinational.
REQ-031 The cycle busy falls, stall deasserts unless a new start in the same cycle re-asserts it.
REQ-032 Back-to-back ops: a start in the first IDLE cycle after done is accepted normally.
REQ-033 All arithmetic uses latched operands only; rs_val/rt_val changes during BUSY do not affect the result.

Reset
REQ-034 reset=1 at a rising edge: state <= IDLE, cnt <= 0, hi <= 0, lo <= 0, done <= 0; busy=0 thereafter.
REQ-035 reset takes priority over md_start in the same cycle.
REQ-036 reset during BUSY aborts the operation: no done pulse, hi/lo = 0.
REQ-037 stall = 0 whenever reset was applied on the previous edge and d_uses_md=0.

Verification
REQ-038 mult rs=0xFFFFFFFE (-2), rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse once.
REQ-039 multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then divu rs=7, rt=0 -> hi/lo unchanged, done still pulses after 10 cycles.
REQ-041 mthi rs=0x12345678 in IDLE -> hi=0x12345678 on the next cycle, busy stays 0. A second mult issued during BUSY is ignored, and the first result commits.
REQ-042 d_uses_md=1 held across a div start -> stall=1 on the start cycle and all 10 busy cycles, 0 in the cycle busy falls.
REQ-043 reset asserted on the 3rd busy cycle of a mult -> next cycle busy=0, hi=lo=0, no done pulse; a new mult starts normally afterwards.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer: holds HI/LO, models the multi-cycle busy window of
// mult/multu/div/divu and raises the D-stage stall for instructions that touch HI/LO.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        start_arith;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, a_mag, b_mag, quo_m, rem_m, quo_s, rem_s, quo_u, rem_u;

  assign start_arith = md_start && (md_op >= OpMult) && (md_op <= OpDivu);

  // Results are computed from the latched operands only and committed on the final busy edge.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // A zero divisor never commits; substituting one keeps the dividers free of X.
  assign b_safe = (b_q == 32'd0) ? 32'd1 : b_q;
  assign quo_u  = a_q / b_safe;
  assign rem_u  = a_q % b_safe;

  // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder.
  assign a_mag  = a_q[31] ? -a_q : a_q;
  assign b_mag  = b_safe[31] ? -b_safe : b_safe;
  assign quo_m  = a_mag / b_mag;
  assign rem_m  = a_mag % b_mag;
  assign quo_s  = (a_q[31] ^ b_safe[31]) ? -quo_m : quo_m;
  assign rem_s  = a_q[31] ? -rem_m : rem_m;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          case (md_op)
            OpMult, OpMultu: begin
              state_d = StBusy;
              cnt_d   = 5'(MULT_CYCLES);
              op_d    = md_op;
              a_d     = rs_val;
              b_d     = rt_val;
            end
            OpDiv, OpDivu: begin
              state_d = StBusy;
              cnt_d   = 5'(DIV_CYCLES);
              op_d    = md_op;
              a_d     = rs_val;
              b_d     = rt_val;
            end
            OpMthi:  hi_d = rs_val;
            OpMtlo:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q > 5'd1) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = StIdle;
          cnt_d   = 5'd0;
          done_d  = 1'b1;
          case (op_q)
            OpMult: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OpMultu: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OpDiv: begin
              if (b_q != 32'd0) begin
                hi_d = rem_s;
                lo_d = quo_s;
              end
            end
            OpDivu: begin
              if (b_q != 32'd0) begin
                hi_d = rem_u;
                lo_d = quo_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == StBusy);
  assign stall = d_uses_md && (busy || start_arith);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected HI/LO pairs are queued at issue time and
// checked when done pulses; busy/stall/done are checked every cycle of each operation.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset, md_start, d_uses_md;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int          tests = 0;
  int          failed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_start  (md_start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    res = {h, l};
    case (op)
      3'd1: begin
        q = sa * sb;
        res = q;
      end
      3'd2: res = {32'b0, a} * {32'b0, b};
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  // Drives one start cycle; leaves the bench in the first busy cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv);
    exp_q.push_back(expv);
    md_start = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    #1;
    if (d_uses_md) begin
      tests++;
      if (stall !== 1'b1) begin
        failed++;
        $display("FAIL stall_on_start: got %b expected 1", stall);
      end
    end
    tick();
    md_start = 1'b0;
    md_op    = 3'd0;
  endtask

  // Walks the n busy cycles, optionally injecting starts that must be ignored, and ends in
  // the cycle busy falls with the result checked against the scoreboard.
  task automatic wait_done(input int n, input bit inject);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      tests++;
      if (busy !== 1'b1) begin
        failed++;
        $display("FAIL busy_cycle%0d: got %b expected 1", i, busy);
      end
      tests++;
      if (done !== 1'b0) begin
        failed++;
        $display("FAIL done_early%0d: got %b expected 0", i, done);
      end
      if (d_uses_md) begin
        tests++;
        if (stall !== 1'b1) begin
          failed++;
          $display("FAIL stall_busy%0d: got %b expected 1", i, stall);
        end
      end
      rs_val   = $urandom;
      rt_val   = $urandom;
      md_start = inject && (i == 1 || i == 2);
      md_op    = (i == 1) ? 3'd1 : 3'd5;
      tick();
    end
    md_start = 1'b0;
    md_op    = 3'd0;
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL busy_fall: got %b expected 0", busy);
    end
    tests++;
    if (done !== 1'b1) begin
      failed++;
      $display("FAIL done_pulse: got %b expected 1", done);
    end
    if (d_uses_md) begin
      tests++;
      if (stall !== 1'b0) begin
        failed++;
        $display("FAIL stall_fall: got %b expected 0", stall);
      end
    end
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      if (hi !== e[63:32] || lo !== e[31:0]) begin
        failed++;
        $display("FAIL result: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e[63:32],
                 e[31:0]);
      end
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  task automatic check_done_low(input string name);
    tests++;
    if (done !== 1'b0) begin
      failed++;
      $display("FAIL %s: got done=%b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    md_start = 1'b1;
    md_op = 3'd1;
    d_uses_md = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    md_start = 1'b0;
    md_op = 3'd0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy, done, stall);
    end
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      failed++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0 0", hi, lo);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_priority: got busy=%b expected 0", busy);
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic test_mult();
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    wait_done(5, 1'b0);
    tick();
    check_done_low("mult_done_once");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    wait_done(5, 1'b0);
    tick();
  endtask

  task automatic test_div();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_done(10, 1'b0);
    tick();
    issue(3'd4, 32'd7, 32'd0, {m_hi, m_lo});
    wait_done(10, 1'b0);
    tick();
    check_done_low("divu_zero_done_once");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    wait_done(10, 1'b0);
    tick();
  endtask

  task automatic test_move();
    md_start = 1'b1;
    md_op = 3'd5;
    rs_val = 32'h1234_5678;
    tick();
    md_op = 3'd6;
    rs_val = 32'hCAFE_F00D;
    tests++;
    if (hi !== 32'h1234_5678 || lo !== m_lo || busy !== 1'b0) begin
      failed++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b expected %h %h 0", hi, lo, busy,
               32'h1234_5678, m_lo);
    end
    tick();
    tests++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      failed++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected 12345678 cafef00d 0", hi, lo, busy);
    end
    m_hi = 32'h1234_5678;
    m_lo = 32'hCAFE_F00D;
    md_op = 3'd7;
    rs_val = 32'hDEAD_BEEF;
    tick();
    md_op = 3'd0;
    tick();
    md_start = 1'b0;
    tests++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      failed++;
      $display("FAIL op_none: got hi=%h lo=%h busy=%b expected %h %h 0", hi, lo, busy, m_hi,
               m_lo);
    end
  endtask

  task automatic test_ignore_busy();
    issue(3'd1, 32'd7, 32'd9, {32'd0, 32'd63});
    wait_done(5, 1'b1);
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL ignored_start: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    d_uses_md = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      failed++;
      $display("FAIL stall_idle: got %b expected 0", stall);
    end
    a = 32'd1000;
    b = 32'hFFFF_FFF9;
    issue(3'd3, a, b, model(3'd3, a, b, m_hi, m_lo));
    wait_done(10, 1'b0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(op, a, b, model(op, a, b, m_hi, m_lo));
      wait_done((op <= 3'd2) ? 5 : 10, 1'b0);
    end
    tick();
    d_uses_md = 1'b0;
    check_done_low("b2b_done_low");
  endtask

  task automatic test_reset_busy();
    issue(3'd1, 32'd5, 32'd6, {32'd0, 32'd30});
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    m_hi = 32'd0;
    m_lo = 32'd0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h stall=%b expected all 0",
               busy, done, hi, lo, stall);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      check_done_low("abort_no_done");
    end
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    wait_done(5, 1'b0);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    md_start = 1'b0;
    md_op = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    d_uses_md = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_ignore_busy();
    test_back_to_back();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
